// File: rtl/boron_key_expander_if.sv
// Key-schedule bus between the expander and its consumer (round controller).
// master = consumer side (drives key/start), slave = expander side.
interface boron_key_expander_if #(
   parameter int KEY_W  = 80,
   parameter int ROUNDS = 25
);
   logic [KEY_W-1:0]              masterKey;
   logic                          keyStart;
   logic [KEY_W*(ROUNDS+1)-1:0]   key_register;
   logic                          keyValid;
   logic                          busy;

   modport master (
      output masterKey,
      output keyStart,
      input  key_register,
      input  keyValid,
      input  busy
   );

   modport slave (
      input  masterKey,
      input  keyStart,
      output key_register,
      output keyValid,
      output busy
   );
endinterface

// File: rtl/boron_key_expander.sv
// Expands an 80-bit master key into ROUNDS+1 round keys, one derived slot per
// cycle, and flags the bank valid once every slot is consistent.
module boron_key_expander #(
   parameter int KEY_W  = 80,
   parameter int ROUNDS = 25
) (
   input  logic                 clk,
   input  logic                 reset,
   boron_key_expander_if.slave  bus
);
   typedef enum logic [0:0] {IDLE, EXPAND} state_t;

   localparam logic [4:0] LAST_RC = 5'(ROUNDS);

   state_t           state_reg, state_next;
   logic [4:0]       rc_reg, rc_next;
   logic [KEY_W-1:0] work_reg, work_next;
   logic             valid_reg, valid_next;
   logic [KEY_W-1:0] round_key;
   logic             start_accept;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: sbox = 4'hE;
         4'h1: sbox = 4'h4;
         4'h2: sbox = 4'hB;
         4'h3: sbox = 4'h1;
         4'h4: sbox = 4'h7;
         4'h5: sbox = 4'h9;
         4'h6: sbox = 4'hC;
         4'h7: sbox = 4'hA;
         4'h8: sbox = 4'hD;
         4'h9: sbox = 4'h2;
         4'hA: sbox = 4'h0;
         4'hB: sbox = 4'hF;
         4'hC: sbox = 4'h8;
         4'hD: sbox = 4'h5;
         4'hE: sbox = 4'h3;
         default: sbox = 4'h6;
      endcase
   endfunction

   // Round function: rotate left 13, substitute low nibble, mix round counter.
   always_comb begin
      logic [KEY_W-1:0] t;
      t         = {work_reg[66:0], work_reg[79:67]};
      t[3:0]    = sbox(t[3:0]);
      t[63:59]  = t[63:59] ^ rc_reg;
      round_key = t;
   end

   assign start_accept = (state_reg == IDLE) && bus.keyStart;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         rc_reg    <= 5'd0;
         work_reg  <= '0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         rc_reg    <= rc_next;
         work_reg  <= work_next;
         valid_reg <= valid_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      rc_next    = rc_reg;
      work_next  = work_reg;
      valid_next = valid_reg;
      case (state_reg)
         IDLE: begin
            if (bus.keyStart) begin
               state_next = EXPAND;
               rc_next    = 5'd1;
               work_next  = bus.masterKey;
               valid_next = 1'b0;
            end
         end
         EXPAND: begin
            work_next = round_key;
            if (rc_reg == LAST_RC) begin
               state_next = IDLE;
               rc_next    = 5'd0;
               valid_next = 1'b1;
            end else begin
               rc_next = rc_reg + 5'd1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Each slot has its own write strobe; untouched slots keep old contents
   // during a re-key, which is why keyValid gates consumer use.
   generate
      for (genvar gi = 0; gi <= ROUNDS; gi++) begin : g_slot
         logic [KEY_W-1:0] slot_reg;
         logic             slot_we;
         logic [KEY_W-1:0] slot_data;

         if (gi == 0) begin : g_master
            assign slot_we   = start_accept;
            assign slot_data = bus.masterKey;
         end else begin : g_derived
            assign slot_we   = (state_reg == EXPAND) && (rc_reg == 5'(gi));
            assign slot_data = round_key;
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               slot_reg <= '0;
            end else if (slot_we) begin
               slot_reg <= slot_data;
            end
         end

         assign bus.key_register[gi*KEY_W +: KEY_W] = slot_reg;
      end
   endgenerate

   assign bus.keyValid = valid_reg;
   assign bus.busy     = (state_reg == EXPAND);
endmodule
